mp3_header_parser: RTL and testbench

Consumes the four MPEG-1 Layer III header bytes routed out by the SD byte demultiplexer (its `header_ov` / `d_out` pair), validates them, and returns frame-delineation fields (`mode`, `prot`, `frame_size`) to that same demultiplexer together with a one-cycle `header_iv` strobe. Frame size is computed with a sequential restoring divider, so the block is a small FSM plus datapath rather than a lookup table.

---
 rtl/mp3_header_parser.sv | 221 ++++++++++++++++++++++
 tb/tb_mp3_header_parser.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mp3_header_parser.sv
// mp3_header_parser
// Collects the four MPEG-1 Layer III header bytes, validates them and returns
// frame-delineation fields. Frame length is 144000*kbps/rate (+padding), and
// it is computed with a 26-step restoring divider.
// Optional feature macro: MP3_HDR_CHECK_EN (header validity checks and hdr_err).
// Without the macro every header is accepted and hdr_err stays low.

module mp3_header_parser (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hdr_iv,
    input  logic [7:0]  hdr_din,
    output logic        header_iv,
    output logic        hdr_err,
    output logic [1:0]  mode,
    output logic        prot,
    output logic        padding,
    output logic [3:0]  bitrate_idx,
    output logic [1:0]  samp_idx,
    output logic [10:0] frame_size,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_DECODE  = 3'd2,
        ST_DIVIDE  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Bitrate index to kbps; reserved indices 0 and 15 map to 32 so the
    // divider datapath always has a sensible numerator.
    function automatic logic [8:0] kbps_lookup(input logic [3:0] idx);
        logic [8:0] kbps;
        case (idx)
            4'd1:    kbps = 9'd32;
            4'd2:    kbps = 9'd40;
            4'd3:    kbps = 9'd48;
            4'd4:    kbps = 9'd56;
            4'd5:    kbps = 9'd64;
            4'd6:    kbps = 9'd80;
            4'd7:    kbps = 9'd96;
            4'd8:    kbps = 9'd112;
            4'd9:    kbps = 9'd128;
            4'd10:   kbps = 9'd160;
            4'd11:   kbps = 9'd192;
            4'd12:   kbps = 9'd224;
            4'd13:   kbps = 9'd256;
            4'd14:   kbps = 9'd320;
            default: kbps = 9'd32;
        endcase
        return kbps;
    endfunction

    // Sample-rate index to Hz; reserved index 3 maps to 44100 so the divisor
    // is never zero.
    function automatic logic [16:0] rate_lookup(input logic [1:0] idx);
        logic [16:0] rate;
        case (idx)
            2'd1:    rate = 17'd48000;
            2'd2:    rate = 17'd32000;
            default: rate = 17'd44100;
        endcase
        return rate;
    endfunction

`ifdef MP3_HDR_CHECK_EN
    // Sync word, MPEG-1, Layer III, and no reserved bitrate/sample-rate codes.
    function automatic logic hdr_valid(input logic [31:0] h);
        return (h[31:21] == 11'h7FF) &&
               (h[20:19] == 2'b11)   &&
               (h[18:17] == 2'b01)   &&
               (h[15:12] != 4'd0)    &&
               (h[15:12] != 4'd15)   &&
               (h[11:10] != 2'b11);
    endfunction
`endif

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic [31:0] hdr_q;
    logic [25:0] num_q;      // dividend shifts out the top, quotient shifts in
    logic [17:0] rem_q;
    logic [16:0] div_q;
    logic [4:0]  bit_cnt_q;

    logic        header_iv_q;
    logic        hdr_err_q;
    logic [1:0]  mode_q;
    logic        prot_q;
    logic        padding_q;
    logic [3:0]  bitrate_idx_q;
    logic [1:0]  samp_idx_q;
    logic [10:0] frame_size_q;
    logic        busy_q;

    logic        hdr_ok_s;
    logic [8:0]  kbps_s;
    logic [16:0] rate_s;
    logic [25:0] num_load_s;
    logic [17:0] rem_shift_s;
    logic [18:0] diff_s;
    logic        qbit_s;
    logic [17:0] rem_d;
    logic        unused_bits_s;

`ifdef MP3_HDR_CHECK_EN
    assign hdr_ok_s = hdr_valid(hdr_q);
`else
    assign hdr_ok_s = 1'b1;
`endif

    assign kbps_s     = kbps_lookup(hdr_q[15:12]);
    assign rate_s     = rate_lookup(hdr_q[11:10]);
    assign num_load_s = {17'd0, kbps_s} * 26'd144000;

    // Header fields not carried to outputs and quotient bits that are always zero.
    assign unused_bits_s = ^{hdr_q[31:16], hdr_q[5:0], num_q[25:11]};

    // One restoring-division step: shift in next dividend bit, trial subtract.
    always_comb begin
        rem_shift_s = {rem_q[16:0], num_q[25]};
        diff_s      = {1'b0, rem_shift_s} - {2'b00, div_q};
        qbit_s      = ~diff_s[18];
        if (qbit_s) begin
            rem_d = diff_s[17:0];
        end else begin
            rem_d = rem_shift_s;
        end
    end

    // Control FSM with datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 2'd0;
            hdr_q         <= 32'd0;
            num_q         <= 26'd0;
            rem_q         <= 18'd0;
            div_q         <= 17'd0;
            bit_cnt_q     <= 5'd0;
            header_iv_q   <= 1'b0;
            hdr_err_q     <= 1'b0;
            mode_q        <= 2'b00;
            prot_q        <= 1'b1;
            padding_q     <= 1'b0;
            bitrate_idx_q <= 4'd0;
            samp_idx_q    <= 2'd0;
            frame_size_q  <= 11'd0;
            busy_q        <= 1'b0;
        end else begin
            header_iv_q <= 1'b0;
            hdr_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE, ST_COLLECT: begin
                    if (hdr_iv) begin
                        hdr_q <= {hdr_q[23:0], hdr_din};
                        if (cnt_q == 2'd3) begin
                            cnt_q   <= 2'd0;
                            state_q <= ST_DECODE;
                            busy_q  <= 1'b1;
                        end else begin
                            cnt_q   <= cnt_q + 2'd1;
                            state_q <= ST_COLLECT;
                        end
                    end
                end
                ST_DECODE: begin
                    if (hdr_ok_s) begin
                        num_q     <= num_load_s;
                        div_q     <= rate_s;
                        rem_q     <= 18'd0;
                        bit_cnt_q <= 5'd0;
                        state_q   <= ST_DIVIDE;
                    end else begin
                        hdr_err_q <= 1'b1;
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                    end
                end
                ST_DIVIDE: begin
                    num_q <= {num_q[24:0], qbit_s};
                    rem_q <= rem_d;
                    if (bit_cnt_q == 5'd25) begin
                        state_q <= ST_DONE;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                    end
                end
                ST_DONE: begin
                    frame_size_q  <= num_q[10:0] + {10'd0, hdr_q[9]};
                    mode_q        <= hdr_q[7:6];
                    prot_q        <= hdr_q[16];
                    padding_q     <= hdr_q[9];
                    bitrate_idx_q <= hdr_q[15:12];
                    samp_idx_q    <= hdr_q[11:10];
                    header_iv_q   <= 1'b1;
                    state_q       <= ST_IDLE;
                    busy_q        <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 2'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign header_iv   = header_iv_q;
    assign hdr_err     = hdr_err_q;
    assign mode        = mode_q;
    assign prot        = prot_q;
    assign padding     = padding_q;
    assign bitrate_idx = bitrate_idx_q;
    assign samp_idx    = samp_idx_q;
    assign frame_size  = frame_size_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mp3_header_parser.sv
// Testbench for mp3_header_parser: scoreboard of expected results pushed when
// a header is driven and popped when the DUT pulses header_iv or hdr_err.

module tb_mp3_header_parser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hdr_iv;
    logic [7:0]  hdr_din;
    logic        header_iv;
    logic        hdr_err;
    logic [1:0]  mode;
    logic        prot;
    logic        padding;
    logic [3:0]  bitrate_idx;
    logic [1:0]  samp_idx;
    logic [10:0] frame_size;
    logic        busy;

    typedef struct {
        logic        is_err;
        logic [10:0] fs;
        logic [1:0]  mode;
        logic        prot;
        logic        pad;
        logic [3:0]  br;
        logic [1:0]  sr;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_exp;
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   last_cyc = 0;

    mp3_header_parser dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hdr_iv      (hdr_iv),
        .hdr_din     (hdr_din),
        .header_iv   (header_iv),
        .hdr_err     (hdr_err),
        .mode        (mode),
        .prot        (prot),
        .padding     (padding),
        .bitrate_idx (bitrate_idx),
        .samp_idx    (samp_idx),
        .frame_size  (frame_size),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model of one header: fields, frame length and latency.
    function automatic exp_t model(input logic [7:0] b0, input logic [7:0] b1,
                                   input logic [7:0] b2, input logic [7:0] b3);
        logic [31:0] h;
        int kb_tab[16] = '{32, 32, 40, 48, 56, 64, 80, 96, 112, 128, 160, 192, 224, 256, 320, 32};
        int sr_tab[4]  = '{44100, 48000, 32000, 44100};
        logic valid;
        exp_t e;
        h = {b0, b1, b2, b3};
        valid = 1'b1;
`ifdef MP3_HDR_CHECK_EN
        valid = (h[31:21] == 11'h7FF) && (h[20:19] == 2'b11) && (h[18:17] == 2'b01) &&
                (h[15:12] != 4'd0) && (h[15:12] != 4'd15) && (h[11:10] != 2'b11);
`endif
        if (!valid) begin
            e        = cur_exp;
            e.is_err = 1'b1;
            e.lat    = 1;
        end else begin
            e.is_err = 1'b0;
            e.fs     = 11'((144000 * kb_tab[h[15:12]]) / sr_tab[h[11:10]] + int'(h[9]));
            e.mode   = h[7:6];
            e.prot   = h[16];
            e.pad    = h[9];
            e.br     = h[15:12];
            e.sr     = h[11:10];
            e.lat    = 28;
        end
        return e;
    endfunction

    task automatic send_hdr(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int gap);
        logic [7:0] bytes [4];
        exp_t e;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        e = model(b0, b1, b2, b3);
        if (!e.is_err) cur_exp = e;
        exp_q.push_back(e);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            hdr_iv  = 1'b1;
            hdr_din = bytes[i];
            @(negedge clk);
            hdr_iv  = 1'b0;
            if (i == 3) begin
                last_cyc = cyc;
            end else begin
                repeat (gap) @(negedge clk);
            end
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        check_val("done_timeout", exp_q.size(), 0);
        @(negedge clk);
        check_val("iv_width", header_iv, 0);
        check_val("err_width", hdr_err, 0);
        check_val("busy_idle", busy, 0);
    endtask

    task automatic check_reset_vals();
        check_val("rst_header_iv", header_iv, 0);
        check_val("rst_hdr_err", hdr_err, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_mode", mode, 0);
        check_val("rst_prot", prot, 1);
        check_val("rst_padding", padding, 0);
        check_val("rst_bitrate", bitrate_idx, 0);
        check_val("rst_samp", samp_idx, 0);
        check_val("rst_frame_size", frame_size, 0);
    endtask

    // Scoreboard: every output pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && (header_iv || hdr_err)) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_pulse", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("pulse_is_err", hdr_err, mon_e.is_err);
                check_val("pulse_is_iv", header_iv, !mon_e.is_err);
                check_val("latency", cyc - last_cyc, mon_e.lat);
                check_val("frame_size", frame_size, mon_e.fs);
                check_val("mode", mode, mon_e.mode);
                check_val("prot", prot, mon_e.prot);
                check_val("padding", padding, mon_e.pad);
                check_val("bitrate_idx", bitrate_idx, mon_e.br);
                check_val("samp_idx", samp_idx, mon_e.sr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cur_exp = '{is_err: 1'b0, fs: 11'd0, mode: 2'd0, prot: 1'b1, pad: 1'b0,
                    br: 4'd0, sr: 2'd0, lat: 0};
        rst_n   = 1'b0;
        hdr_iv  = 1'b0;
        hdr_din = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 128 kbps, 44.1 kHz, joint stereo: 417
        send_hdr(8'hFF, 8'hFB, 8'h90, 8'h64, 3);
        wait_done();
        // no CRC bit clear, padding, mono: 418
        send_hdr(8'hFF, 8'hFA, 8'h92, 8'hC4, 0);
        wait_done();
        // 320 kbps, 32 kHz, padding: largest frame 1441
        send_hdr(8'hFF, 8'hFB, 8'hEA, 8'h00, 1);
        wait_done();
        // reserved bitrate index 15: rejected when checking, else 32 kbps
        send_hdr(8'hFF, 8'hFB, 8'hF0, 8'h00, 2);
        wait_done();
        send_hdr(8'hFF, 8'hFB, 8'h90, 8'h64, 0);
        wait_done();
        // reserved sample-rate index 3
        send_hdr(8'hFF, 8'hFB, 8'h9C, 8'h00, 0);
        wait_done();
        // bad sync word
        send_hdr(8'h12, 8'h34, 8'h56, 8'h40, 0);
        wait_done();

        // reset during divide discards everything
        send_hdr(8'hFF, 8'hFA, 8'h92, 8'hC4, 0);
        repeat (11) @(negedge clk);
        check_val("busy_in_divide", busy, 1);
        rst_n = 1'b0;
        exp_q.delete();
        cur_exp = '{is_err: 1'b0, fs: 11'd0, mode: 2'd0, prot: 1'b1, pad: 1'b0,
                    br: 4'd0, sr: 2'd0, lat: 0};
        @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_val("no_pulse_after_rst", exp_q.size(), 0);
        check_val("fs_after_rst", frame_size, 0);
        send_hdr(8'hFF, 8'hFB, 8'hEA, 8'h00, 0);
        wait_done();

        // stray byte while busy is ignored
        send_hdr(8'hFF, 8'hFB, 8'h90, 8'h64, 1);
        repeat (5) @(negedge clk);
        check_val("busy_set", busy, 1);
        hdr_iv  = 1'b1;
        hdr_din = 8'hAA;
        @(negedge clk);
        hdr_iv  = 1'b0;
        wait_done();
        send_hdr(8'hFF, 8'hFA, 8'h92, 8'hC4, 2);
        wait_done();

        check_val("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
